led_manager: RTL and testbench
==============================

Name: led_manager

Overview:
- Drives the board's 16 status LEDs from UART receive data, UART receive errors, configuration-manager (CM) errors and the current configuration word.
- Sits at the top level beside the UART receiver and the configuration manager, in the single system clock domain.
- A debug switch selects between a UART data-debug view and a normal status view.

Parameters:
- HEARTBEAT_DIV, 25000000: clk cycles between heartbeat LED toggles; legal range ≥2.
- ACT_STRETCH, 8: clk cycles the activity LED stays lit after a UART byte strobe; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- UART_data_debug_switch  in  1  1 = debug view, 0 = status view; sampled every cycle.
- UART_data  in  8  received UART byte; valid when UART_data_valid=1.
- UART_data_valid  in  1  byte strobe; each high cycle is one capture.
- CM_errors  in  4  CM error flags; valid when CM_errors_valid=1.
- CM_errors_valid  in  1  CM error strobe.
- UART_errors  in  2  UART error flags: bit1 framing, bit0 overrun.
- UART_errors_valid  in  1  UART error strobe.
- config_notification  in  8  current configuration word; level input.
- leds  out  16  LED drive, 1 = lit.

Behaviour:
- Reset: all internal registers are 0, so leds = 16'h0000 on the cycle after rst is sampled high. Reset overrides every other event in the same cycle.
- Internal registers:
  - last_byte[7:0]: loads UART_data when UART_data_valid=1.
  - byte_cnt[7:0]: increments by 1 on each valid cycle; wraps 255→0.
  - cfg_q[7:0]: registered config_notification, updated every cycle.
  - cm_err[3:0]: sticky; cm_err |= CM_errors when CM_errors_valid=1.
  - uart_err[1:0]: sticky; uart_err |= UART_errors when UART_errors_valid=1.
  - act_cnt: loads ACT_STRETCH on a valid cycle, otherwise decrements to 0 and stops there.
  - hb_cnt / hb: hb_cnt counts 0..HEARTBEAT_DIV-1; hb toggles on wrap.
- Error clear:
  - When config_notification != cfg_q (configuration change), cm_err and uart_err clear.
  - If an error strobe occurs in the same cycle, the register loads exactly the new flags: the clear applies first, then the OR.
- Status view (switch = 0):
  - leds[15:8] = cfg_q
  - leds[7:4] = cm_err
  - leds[3:2] = uart_err
  - leds[1] = (act_cnt != 0)
  - leds[0] = hb
- Debug view (switch = 1):
  - leds[15:8] = last_byte
  - leds[7:0] = byte_cnt
- Timing:
  - leds is a register: one clk latency from any sampled input, including the switch.
  - All registers keep updating in both views; a view switch loses no state.
- Same-cycle strobes: simultaneous strobes on different inputs are all processed in that cycle.

Optional Feature:
- ERROR_BLINK_EN defined: status-view leds[7:2] = {cm_err, uart_err} & {6{hb}}, so latched errors blink at heartbeat rate.
- ERROR_BLINK_EN undefined: error LEDs are steady as described above.
- The debug view is unaffected either way.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> leds=16'h0000 the cycle after; hb_cnt restarts.
- Status view, config_notification=8'h81, then CM_errors=4'b1101 strobe and UART_errors=2'b01 strobe -> leds[15:8]=8'h81, leds[7:4]=4'b1101, leds[3:2]=2'b01. A second CM strobe 4'b0010 -> leds[7:4]=4'b1111.
- Config change 8'h81→8'h8D with a CM strobe of 4'b0100 in the same cycle -> leds[7:4]=4'b0100, leds[3:2]=2'b00, leds[15:8]=8'h8D.
- Debug view, UART bytes 8'hDD, 8'hD1, 8'hAA as 1-cycle strobes -> leds=16'hAA03; switch to 0 -> leds[15:8]=cfg_q one cycle later; 256 bytes -> byte_cnt wraps to 0.
- Activity and heartbeat with HEARTBEAT_DIV=4, ACT_STRETCH=3: one byte strobe -> leds[1] high exactly 3 cycles; leds[0] toggles every 4 cycles.
- ERROR_BLINK_EN build: cm_err=4'b1101 -> leds[7:4] alternates 4'b1101 / 4'b0000 in phase with leds[0].

Source files
------------

// File: rtl/led_manager_if.sv
// Status-LED manager bus: UART/CM event inputs, config word, debug switch and LED drive.
interface led_manager_if;
  logic        UART_data_debug_switch;
  logic [7:0]  UART_data;
  logic        UART_data_valid;
  logic [3:0]  CM_errors;
  logic        CM_errors_valid;
  logic [1:0]  UART_errors;
  logic        UART_errors_valid;
  logic [7:0]  config_notification;
  logic [15:0] leds;

  // Source side: drives the events, observes the LEDs
  modport master (
    output UART_data_debug_switch, UART_data, UART_data_valid,
           CM_errors, CM_errors_valid, UART_errors, UART_errors_valid,
           config_notification,
    input  leds
  );

  // LED manager side
  modport slave (
    input  UART_data_debug_switch, UART_data, UART_data_valid,
           CM_errors, CM_errors_valid, UART_errors, UART_errors_valid,
           config_notification,
    output leds
  );
endinterface

// File: rtl/led_manager.sv
// Drives 16 status LEDs from UART data/errors, CM errors and the config word.
// Optional macro ERROR_BLINK_EN: latched error LEDs blink with the heartbeat.
// The LED register is loaded from the next-state values of all internal
// registers, so every sampled input reaches the LEDs with one cycle latency.
module led_manager #(
  parameter int unsigned HEARTBEAT_DIV = 25000000,
  parameter int unsigned ACT_STRETCH   = 8
) (
  input logic           clk,
  input logic           rst,
  led_manager_if.slave  bus
);
  localparam int unsigned HB_W  = (HEARTBEAT_DIV > 2) ? $clog2(HEARTBEAT_DIV) : 1;
  localparam int unsigned ACT_W = $clog2(ACT_STRETCH + 1);

  logic [7:0]       r_last_byte, w_last_byte_nxt;
  logic [7:0]       r_byte_cnt,  w_byte_cnt_nxt;
  logic [7:0]       r_cfg_q,     w_cfg_q_nxt;
  logic [3:0]       r_cm_err,    w_cm_err_nxt;
  logic [1:0]       r_uart_err,  w_uart_err_nxt;
  logic [ACT_W-1:0] r_act_cnt,   w_act_cnt_nxt;
  logic [HB_W-1:0]  r_hb_cnt,    w_hb_cnt_nxt;
  logic             r_hb,        w_hb_nxt;
  logic [15:0]      r_leds,      w_leds_nxt;
  logic             w_cfg_chg;
  logic [5:0]       w_err_view;

  // Next-state of all tracking registers and the LED image built from them
  always_comb begin
    w_cfg_chg       = (bus.config_notification != r_cfg_q);
    w_cfg_q_nxt     = bus.config_notification;
    w_last_byte_nxt = r_last_byte;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_act_cnt_nxt   = r_act_cnt;
    w_hb_cnt_nxt    = r_hb_cnt + HB_W'(1);
    w_hb_nxt        = r_hb;

    if (bus.UART_data_valid) begin
      w_last_byte_nxt = bus.UART_data;
      w_byte_cnt_nxt  = r_byte_cnt + 8'd1;
      w_act_cnt_nxt   = ACT_W'(ACT_STRETCH);
    end else if (r_act_cnt != '0) begin
      w_act_cnt_nxt   = r_act_cnt - ACT_W'(1);
    end

    // Config change clears first, then a same-cycle strobe ORs in fresh flags
    w_cm_err_nxt   = w_cfg_chg ? 4'b0000 : r_cm_err;
    w_uart_err_nxt = w_cfg_chg ? 2'b00   : r_uart_err;
    if (bus.CM_errors_valid)   w_cm_err_nxt   = w_cm_err_nxt   | bus.CM_errors;
    if (bus.UART_errors_valid) w_uart_err_nxt = w_uart_err_nxt | bus.UART_errors;

    if (r_hb_cnt == HB_W'(HEARTBEAT_DIV - 1)) begin
      w_hb_cnt_nxt = '0;
      w_hb_nxt     = ~r_hb;
    end

`ifdef ERROR_BLINK_EN
    w_err_view = {w_cm_err_nxt, w_uart_err_nxt} & {6{w_hb_nxt}};
`else
    w_err_view = {w_cm_err_nxt, w_uart_err_nxt};
`endif

    if (bus.UART_data_debug_switch)
      w_leds_nxt = {w_last_byte_nxt, w_byte_cnt_nxt};
    else
      w_leds_nxt = {w_cfg_q_nxt, w_err_view, (w_act_cnt_nxt != '0), w_hb_nxt};
  end

  // State and LED registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_byte <= '0;
      r_byte_cnt  <= '0;
      r_cfg_q     <= '0;
      r_cm_err    <= '0;
      r_uart_err  <= '0;
      r_act_cnt   <= '0;
      r_hb_cnt    <= '0;
      r_hb        <= 1'b0;
      r_leds      <= '0;
    end else begin
      r_last_byte <= w_last_byte_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_cfg_q     <= w_cfg_q_nxt;
      r_cm_err    <= w_cm_err_nxt;
      r_uart_err  <= w_uart_err_nxt;
      r_act_cnt   <= w_act_cnt_nxt;
      r_hb_cnt    <= w_hb_cnt_nxt;
      r_hb        <= w_hb_nxt;
      r_leds      <= w_leds_nxt;
    end
  end

  assign bus.leds = r_leds;
endmodule

// File: tb/tb_led_manager.sv
// Self-checking bench for led_manager: behavioural model plus directed literals.
module tb_led_manager;
  localparam int unsigned HB_DIV = 4;
  localparam int unsigned ACT_N  = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  led_manager_if bus_if();

  led_manager #(.HEARTBEAT_DIV(HB_DIV), .ACT_STRETCH(ACT_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic        chk_en = 1'b0;
  logic [15:0] exp_leds = '0;

  // Model state: plain event history rather than counters
  logic [7:0] m_last, m_cfg;
  int         m_bytes;
  logic [3:0] m_cm;
  logic [1:0] m_ue;
  int         m_n;
  int         m_act_at;
  bit         m_act_seen;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Apply one rising edge to the model using the inputs sampled at that edge
  task automatic model_edge();
    logic [5:0] err;
    logic       hb, act;
    if (rst) begin
      m_last = '0; m_cfg = '0; m_bytes = 0; m_cm = '0; m_ue = '0;
      m_n = 0; m_act_at = 0; m_act_seen = 0;
      exp_leds = '0;
    end else begin
      m_n++;
      if (bus_if.config_notification != m_cfg) begin m_cm = '0; m_ue = '0; end
      if (bus_if.CM_errors_valid)   m_cm = m_cm | bus_if.CM_errors;
      if (bus_if.UART_errors_valid) m_ue = m_ue | bus_if.UART_errors;
      m_cfg = bus_if.config_notification;
      if (bus_if.UART_data_valid) begin
        m_last = bus_if.UART_data;
        m_bytes++;
        m_act_at = m_n;
        m_act_seen = 1;
      end
      hb  = ((m_n / HB_DIV) % 2) == 1;
      act = m_act_seen && ((m_n - m_act_at) < ACT_N);
      err = {m_cm, m_ue};
`ifdef ERROR_BLINK_EN
      if (!hb) err = '0;
`endif
      if (bus_if.UART_data_debug_switch)
        exp_leds = {m_last, 8'(m_bytes % 256)};
      else
        exp_leds = {m_cfg, err, act, hb};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus_if.UART_data_valid   = 1'b0;
    bus_if.CM_errors_valid   = 1'b0;
    bus_if.UART_errors_valid = 1'b0;
  endtask

  task automatic randomize_inputs(input int cfg_chg_pct);
    bus_if.UART_data         = 8'($urandom);
    bus_if.UART_data_valid   = ($urandom_range(0, 2) == 0);
    bus_if.CM_errors         = 4'($urandom);
    bus_if.CM_errors_valid   = ($urandom_range(0, 7) == 0);
    bus_if.UART_errors       = 2'($urandom);
    bus_if.UART_errors_valid = ($urandom_range(0, 7) == 0);
    if (int'($urandom_range(0, 99)) < cfg_chg_pct) bus_if.config_notification = 8'($urandom);
  endtask

  // Cycle-by-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) check("leds_cycle", bus_if.leds, exp_leds);
  end

  initial begin
    logic [7:0] dbg_bytes [3];
    dbg_bytes[0] = 8'hDD; dbg_bytes[1] = 8'hD1; dbg_bytes[2] = 8'hAA;

    // Reset with random inputs
    rst = 1'b1;
    bus_if.UART_data_debug_switch = 1'b0;
    bus_if.config_notification = 8'h00;
    randomize_inputs(100);
    step();
    randomize_inputs(100);
    step();
    chk_en = 1'b1;
    check("reset_leds", bus_if.leds, 16'h0000);

    // Status view: config, CM and UART error strobes
    rst = 1'b0;
    idle();
    bus_if.UART_data_debug_switch = 1'b0;
    bus_if.config_notification = 8'h81;
    step();
    bus_if.CM_errors = 4'b1101; bus_if.CM_errors_valid = 1'b1;
    step();
    idle();
    bus_if.UART_errors = 2'b01; bus_if.UART_errors_valid = 1'b1;
    step();
    idle();
    step();
    check("status_cfg", {8'h00, bus_if.leds[15:8]}, 16'h0081);
`ifndef ERROR_BLINK_EN
    check("status_cm", {12'h000, bus_if.leds[7:4]}, 16'h000D);
    check("status_uart", {14'h0000, bus_if.leds[3:2]}, 16'h0001);
`endif
    bus_if.CM_errors = 4'b0010; bus_if.CM_errors_valid = 1'b1;
    step();
    idle();
`ifndef ERROR_BLINK_EN
    check("cm_sticky", {12'h000, bus_if.leds[7:4]}, 16'h000F);
`endif

    // Config change with a same-cycle CM strobe
    bus_if.config_notification = 8'h8D;
    bus_if.CM_errors = 4'b0100; bus_if.CM_errors_valid = 1'b1;
    step();
    idle();
    check("chg_cfg", {8'h00, bus_if.leds[15:8]}, 16'h008D);
    check("chg_uart_clr", {14'h0000, bus_if.leds[3:2]}, 16'h0000);
`ifndef ERROR_BLINK_EN
    check("chg_cm_new", {12'h000, bus_if.leds[7:4]}, 16'h0004);
`endif

`ifdef ERROR_BLINK_EN
    // Blinking errors follow the heartbeat phase
    rst = 1'b1; step(); rst = 1'b0;
    bus_if.config_notification = 8'h81;
    step();
    bus_if.CM_errors = 4'b1101; bus_if.CM_errors_valid = 1'b1;
    step();
    idle();
    for (int i = 0; i < 10; i++) begin
      step();
      check("blink_cm", {12'h000, bus_if.leds[7:4]},
            (((m_n / HB_DIV) % 2) == 1) ? 16'h000D : 16'h0000);
    end
`endif

    // Debug view: three bytes, then view switch, then counter wrap
    rst = 1'b1; step(); rst = 1'b0;
    idle();
    bus_if.config_notification = 8'h5A;
    bus_if.UART_data_debug_switch = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_if.UART_data = dbg_bytes[i]; bus_if.UART_data_valid = 1'b1;
      step();
      bus_if.UART_data_valid = 1'b0;
      step();
    end
    check("debug_bytes", bus_if.leds, 16'hAA03);
    bus_if.UART_data_debug_switch = 1'b0;
    step();
    check("view_switch_cfg", {8'h00, bus_if.leds[15:8]}, 16'h005A);
    bus_if.UART_data_debug_switch = 1'b1;
    bus_if.UART_data = 8'h3C;
    for (int i = 0; i < 253; i++) begin
      bus_if.UART_data_valid = 1'b1;
      step();
    end
    bus_if.UART_data_valid = 1'b0;
    step();
    check("byte_cnt_wrap", bus_if.leds, 16'h3C00);

    // Activity stretch and heartbeat timing from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    idle();
    bus_if.UART_data_debug_switch = 1'b0;
    bus_if.config_notification = 8'h00;
    bus_if.UART_data_valid = 1'b1;
    step();
    bus_if.UART_data_valid = 1'b0;
    check("act_k1", {15'h0000, bus_if.leds[1]}, 16'h0001);
    step();
    check("act_k2", {15'h0000, bus_if.leds[1]}, 16'h0001);
    step();
    check("act_k3", {15'h0000, bus_if.leds[1]}, 16'h0001);
    check("hb_k3", {15'h0000, bus_if.leds[0]}, 16'h0000);
    step();
    check("act_k4", {15'h0000, bus_if.leds[1]}, 16'h0000);
    check("hb_k4", {15'h0000, bus_if.leds[0]}, 16'h0001);
    step(); step(); step();
    check("hb_k7", {15'h0000, bus_if.leds[0]}, 16'h0001);
    step();
    check("hb_k8", {15'h0000, bus_if.leds[0]}, 16'h0000);

    // Randomized traffic with occasional resets and view changes
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0)
        bus_if.UART_data_debug_switch = ~bus_if.UART_data_debug_switch;
      randomize_inputs(6);
      step();
    end

    chk_en = 1'b0;
    @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
